io_sequencer: RTL and testbench

Multi-cycle sequencer for the processor's input, output and halt instructions. It consumes the decoder's Input/Output/Halt flags and stalls the PC while an input instruction waits for the operator's confirm button. It latches switch data for register writeback, holds the display register for output instructions, and freezes the core on halt. It sits between the control decoder, the PC register, the register-file write port and the board I/O.

---
 rtl/io_sequencer.sv | 151 +++++++++++++++
 tb/tb_io_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_sequencer.sv
// Multi-cycle sequencer for IN / OUT / HALT instructions: stalls the PC until a
// debounced confirm press arrives, latches switches, drives the display, freezes on halt.
module io_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_op,
  input  logic                  output_op,
  input  logic                  halt_op,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  btn_confirm,
  input  logic [DATA_WIDTH-1:0] out_src,
  output logic                  pc_en,
  output logic                  in_we,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  display_valid,
  output logic                  waiting_input,
  output logic                  halted
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_IN_ARM    = 3'd1,
    ST_IN_WAIT   = 3'd2,
    ST_IN_COMMIT = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  btn_stable_q, btn_stable_d;
  logic                  btn_prev_q, btn_prev_d;
  logic                  press_q, press_d;
  logic                  in_we_q, in_we_d;
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic [DATA_WIDTH-1:0] display_q, display_d;
  logic                  display_valid_q, display_valid_d;
  logic                  waiting_input_q, waiting_input_d;
  logic                  halted_q, halted_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_RUN;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      cnt_q           <= '0;
      btn_stable_q    <= 1'b0;
      btn_prev_q      <= 1'b0;
      press_q         <= 1'b0;
      in_we_q         <= 1'b0;
      in_data_q       <= '0;
      display_q       <= '0;
      display_valid_q <= 1'b0;
      waiting_input_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      cnt_q           <= cnt_d;
      btn_stable_q    <= btn_stable_d;
      btn_prev_q      <= btn_prev_d;
      press_q         <= press_d;
      in_we_q         <= in_we_d;
      in_data_q       <= in_data_d;
      display_q       <= display_d;
      display_valid_q <= display_valid_d;
      waiting_input_q <= waiting_input_d;
      halted_q        <= halted_d;
    end
  end

  // Button conditioning: the counter only runs while the synchronized level disagrees.
  always_comb begin
    sync1_d      = btn_confirm;
    sync2_d      = sync1_q;
    cnt_d        = '0;
    btn_stable_d = btn_stable_q;
    if (sync2_q != btn_stable_q) begin
      if (cnt_q == CNT_LAST) begin
        btn_stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    btn_prev_d = btn_stable_q;
    press_d    = btn_stable_q & ~btn_prev_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_op) begin
          state_d = ST_HALTED;
        end else if (input_op) begin
          state_d = btn_stable_q ? ST_IN_ARM : ST_IN_WAIT;
        end
      end
      ST_IN_ARM:    if (!btn_stable_q) state_d = ST_IN_WAIT;
      ST_IN_WAIT:   if (press_q) state_d = ST_IN_COMMIT;
      ST_IN_COMMIT: state_d = ST_RUN;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_RUN;
    endcase
  end

  // Status flags are decoded from the next state so they leave flops cleanly.
  always_comb begin
    case (state_q)
      ST_RUN:       pc_en = ~(halt_op | input_op);
      ST_IN_COMMIT: pc_en = 1'b1;
      default:      pc_en = 1'b0;
    endcase
    if (reset) pc_en = 1'b0;

    in_we_d         = (state_d == ST_IN_COMMIT);
    waiting_input_d = (state_d == ST_IN_ARM) || (state_d == ST_IN_WAIT);
    halted_d        = (state_d == ST_HALTED);

    in_data_d = in_data_q;
    if ((state_q == ST_IN_WAIT) && press_q) begin
      in_data_d                 = '0;
      in_data_d[SW_WIDTH-1:0]   = sw;
    end

    display_d       = display_q;
    display_valid_d = display_valid_q;
    if ((state_q == ST_RUN) && !halt_op && !input_op && output_op) begin
      display_d       = out_src;
      display_valid_d = 1'b1;
    end
  end

  assign in_we         = in_we_q;
  assign in_data       = in_data_q;
  assign display       = display_q;
  assign display_valid = display_valid_q;
  assign waiting_input = waiting_input_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed scenarios plus randomized traffic, all checked
// every cycle against a history-based behavioural model of the sequencer.
module tb_io_sequencer;
  localparam int DW   = 32;
  localparam int SW   = 16;
  localparam int DB   = 4;
  localparam int MAXC = 16384;
  localparam int M_RUN = 0, M_ARM = 1, M_WAIT = 2, M_COMMIT = 3, M_HALT = 4;

  logic          clock = 1'b0;
  logic          reset, input_op, output_op, halt_op, btn_confirm;
  logic [SW-1:0] sw;
  logic [DW-1:0] out_src;
  logic          pc_en, in_we, display_valid, waiting_input, halted;
  logic [DW-1:0] in_data, display;

  io_sequencer #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .input_op(input_op), .output_op(output_op),
    .halt_op(halt_op), .sw(sw), .btn_confirm(btn_confirm), .out_src(out_src),
    .pc_en(pc_en), .in_we(in_we), .in_data(in_data), .display(display),
    .display_valid(display_valid), .waiting_input(waiting_input), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Model state: histories of the raw button, debounced level and press pulse, by edge index.
  bit            raw_h [MAXC];
  bit            st_h  [MAXC];
  bit            pr_h  [MAXC];
  int            ecount   = 0;
  int            last_rst = 0;
  int            run_len  = 0;
  bit            model_live = 0;
  int            m_mode = M_RUN;
  logic [DW-1:0] m_in_data = '0;
  logic [DW-1:0] m_display = '0;
  bit            m_dv = 0;
  bit            m_last_pc = 0;

  // Compare outputs for the current cycle, then advance the model across the next edge.
  always @(negedge clock) begin : model_and_compare
    int e;
    bit exp_pc, stable_now, press_now, sync_now;
    exp_pc = !reset && ((m_mode == M_RUN && !halt_op && !input_op) || m_mode == M_COMMIT);
    if (model_live) begin
      chk_bit("pc_en", pc_en, exp_pc);
      chk_bit("in_we", in_we, m_mode == M_COMMIT);
      chk_bit("waiting_input", waiting_input, m_mode == M_ARM || m_mode == M_WAIT);
      chk_bit("halted", halted, m_mode == M_HALT);
      chk_word("in_data", in_data, m_in_data);
      chk_word("display", display, m_display);
      chk_bit("display_valid", display_valid, m_dv);
    end
    m_last_pc = exp_pc;

    ecount++;
    e = ecount;
    raw_h[(e - 1) % MAXC] = btn_confirm;
    if (reset) begin
      last_rst        = e;
      st_h[e % MAXC]  = 1'b0;
      pr_h[e % MAXC]  = 1'b0;
      run_len         = 0;
      m_mode          = M_RUN;
      m_in_data       = '0;
      m_display       = '0;
      m_dv            = 1'b0;
      model_live      = 1'b1;
    end else if (model_live) begin
      stable_now = st_h[(e - 1) % MAXC];
      press_now  = pr_h[(e - 1) % MAXC];
      // The synchronized level seen in a cycle is the raw level two cycles earlier.
      sync_now = (e - 3 >= last_rst) ? raw_h[(e - 3) % MAXC] : 1'b0;
      st_h[e % MAXC] = stable_now;
      if (sync_now != stable_now) begin
        run_len++;
        if (run_len >= DB) begin
          st_h[e % MAXC] = sync_now;
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
      pr_h[e % MAXC] = (e - 2 >= last_rst) ? (st_h[(e - 1) % MAXC] && !st_h[(e - 2) % MAXC]) : 1'b0;

      case (m_mode)
        M_RUN: begin
          if (halt_op) m_mode = M_HALT;
          else if (input_op) m_mode = stable_now ? M_ARM : M_WAIT;
          else if (output_op) begin
            m_display = out_src;
            m_dv      = 1'b1;
          end
        end
        M_ARM:  if (!stable_now) m_mode = M_WAIT;
        M_WAIT: if (press_now) begin
          m_in_data = DW'(sw);
          m_mode    = M_COMMIT;
        end
        M_COMMIT: m_mode = M_RUN;
        default: ;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Button rises in the first cycle of the task; commit must land on the 8th edge after that.
  task automatic press_commit(input string tag, input logic [SW-1:0] val);
    int got_k, stall_bad;
    got_k = -1;
    stall_bad = 0;
    cyc();
    sw = val;
    btn_confirm = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (k == 10) btn_confirm = 1'b0;
      if (got_k >= 0 && k == got_k + 1) begin
        input_op = 1'b0;
        sw = ~val;
      end
      @(negedge clock);
      if (got_k < 0) begin
        if (in_we) begin
          got_k = k;
          chk_bit({tag, "_commit_pc_en"}, pc_en, 1'b1);
          chk_word({tag, "_in_data"}, in_data, DW'(val));
        end else if (pc_en) begin
          stall_bad++;
        end
      end else if (k == got_k + 1) begin
        chk_bit({tag, "_in_we_single"}, in_we, 1'b0);
        chk_bit({tag, "_back_to_run"}, waiting_input, 1'b0);
        chk_bit({tag, "_run_pc_en"}, pc_en, 1'b1);
      end
    end
    chk_word({tag, "_latency"}, DW'(got_k), 32'd8);
    chk_word({tag, "_stall_leak"}, DW'(stall_bad), 32'd0);
  endtask

  initial begin
    int bad, seg_left, halt_cnt, r;
    reset = 1'b1; input_op = 1'b0; output_op = 1'b0; halt_op = 1'b0;
    btn_confirm = 1'b0; sw = '0; out_src = '0;
    repeat (2) cyc();
    @(negedge clock);
    chk_bit("reset_pc_en", pc_en, 1'b0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk_word("rst_in_data", in_data, 32'h0);
    chk_word("rst_display", display, 32'h0);
    chk_bit("rst_display_valid", display_valid, 1'b0);
    chk_bit("rst_waiting", waiting_input, 1'b0);
    chk_bit("rst_halted", halted, 1'b0);
    chk_bit("rst_run_pc_en", pc_en, 1'b1);

    // Plain input instruction.
    cyc(); input_op = 1'b1; sw = 16'h00A5;
    cyc(); cyc();
    press_commit("t1", 16'h00A5);

    // Button already held when the input instruction arrives.
    cyc(); btn_confirm = 1'b1;
    repeat (10) cyc();
    input_op = 1'b1;
    cyc();
    @(negedge clock);
    chk_bit("t2_armed_waiting", waiting_input, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); @(negedge clock);
      if (in_we || pc_en) bad++;
    end
    cyc(); btn_confirm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(); @(negedge clock);
      if (in_we || pc_en) bad++;
    end
    chk_word("t2_no_commit_while_held", DW'(bad), 32'd0);
    press_commit("t2", 16'h1234);

    // Short glitch must not count as a press.
    cyc(); input_op = 1'b1;
    cyc(); cyc();
    btn_confirm = 1'b1;
    repeat (3) cyc();
    btn_confirm = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(); @(negedge clock);
      if (pc_en || in_we || !waiting_input) bad++;
    end
    chk_word("t3_glitch_ignored", DW'(bad), 32'd0);
    chk_word("t3_in_data_kept", in_data, 32'h0000_1234);
    press_commit("t3", 16'hBEEF);

    // Output instruction.
    cyc(); output_op = 1'b1; out_src = 32'hDEAD_BEEF;
    @(negedge clock);
    chk_bit("t4_no_stall", pc_en, 1'b1);
    chk_bit("t4_valid_before", display_valid, 1'b0);
    cyc(); output_op = 1'b0; out_src = 32'h1234_5678;
    @(negedge clock);
    chk_word("t4_display", display, 32'hDEAD_BEEF);
    chk_bit("t4_display_valid", display_valid, 1'b1);

    // Halt wins over input and sticks until reset.
    cyc(); halt_op = 1'b1; input_op = 1'b1;
    @(negedge clock);
    chk_bit("t5_halt_pc_en", pc_en, 1'b0);
    cyc(); halt_op = 1'b0; input_op = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      btn_confirm = 1'((i / 12) % 2);
      output_op   = 1'($urandom_range(0, 1));
      input_op    = 1'($urandom_range(0, 1));
      out_src     = $urandom;
      @(negedge clock);
      if (!halted || pc_en || in_we || display !== 32'hDEAD_BEEF) bad++;
    end
    chk_word("t5_frozen", DW'(bad), 32'd0);
    cyc(); reset = 1'b1; input_op = 1'b0; output_op = 1'b0; btn_confirm = 1'b0;
    cyc(); reset = 1'b0;
    @(negedge clock);
    chk_bit("t5_unhalted", halted, 1'b0);
    chk_word("t5_display_cleared", display, 32'h0);
    chk_bit("t5_valid_cleared", display_valid, 1'b0);
    chk_word("t5_in_data_cleared", in_data, 32'h0);

    // Reset in the middle of a debounce while waiting.
    cyc(); input_op = 1'b1;
    cyc(); cyc();
    btn_confirm = 1'b1;
    repeat (4) cyc();
    reset = 1'b1; input_op = 1'b0;
    cyc(); reset = 1'b0;
    @(negedge clock);
    chk_bit("t6_not_waiting", waiting_input, 1'b0);
    chk_bit("t6_no_we", in_we, 1'b0);
    chk_bit("t6_run_pc_en", pc_en, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); @(negedge clock);
      if (in_we || waiting_input) bad++;
    end
    chk_word("t6_no_spurious_we", DW'(bad), 32'd0);
    cyc(); btn_confirm = 1'b0;
    repeat (12) cyc();

    // Randomized traffic; a new instruction is issued only after the model says the PC moved.
    seg_left = 0;
    halt_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      cyc();
      reset = 1'b0;
      if (seg_left == 0) begin
        btn_confirm = 1'($urandom_range(0, 1));
        seg_left = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 25));
      end
      seg_left--;
      sw      = SW'($urandom);
      out_src = $urandom;
      if (m_mode == M_HALT) halt_cnt++;
      else halt_cnt = 0;
      if ((halt_cnt > 20 || $urandom_range(0, 399) == 0) && m_mode != M_COMMIT) begin
        reset = 1'b1;
        halt_cnt = 0;
        input_op = 1'b0; output_op = 1'b0; halt_op = 1'b0;
      end else if (m_last_pc) begin
        r = int'($urandom_range(0, 99));
        halt_op   = (r < 2);
        input_op  = (r >= 2 && r < 27) || (r == 0);
        output_op = (r >= 27 && r < 55) || (r == 1);
      end
    end
    cyc();
    input_op = 1'b0; output_op = 1'b0; halt_op = 1'b0; reset = 1'b0;
    repeat (2) cyc();
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
